class_argmax_writer: RTL and testbench

Upstream stage of the segmentation display path: consumes the per-pixel class-score stream from the network output layer, selects the winning class per pixel (argmax), and writes the 8-bit class ID into the class-map output buffer in raster order. The display stage later reads that buffer by `pixel_addr` and maps class IDs to VGA colours. One frame is processed per `start`; `done` tells the controller the buffer is complete and may be handed to display.

---
 rtl/class_argmax_writer.sv | 190 +++++++++++++++++++
 tb/tb_class_argmax_writer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/class_argmax_writer.sv
// -----------------------------------------------------------------------------
// class_argmax_writer
//
// Consumes the per-pixel class-score stream (class 0 first, pixels in raster
// order), selects the winning class of each pixel and writes its 8-bit class
// ID into the class-map buffer at the pixel's raster index. One frame is
// processed per accepted start; done is held until the next accepted start.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        begin a frame (accepted only in IDLE or DONE)
//   score_valid  score beat valid
//   score_data   signed score, SCORE_WIDTH bits
//   score_ready  beat accepted when score_valid && score_ready
//   wr_en        one-cycle buffer write strobe
//   wr_addr      pixel index = row*IMAGE_WIDTH + col
//   wr_data      winning class ID, zero-extended to 8 bits
//   busy         frame in progress (RUN or FLUSH)
//   done         frame complete
//
// Optional feature macro: ARGMAX_CONF_THRESH_EN
//   When defined, a pixel whose winning score is below CONF_THRESH (signed)
//   is written as class 0 (background). Write timing is unchanged.
// -----------------------------------------------------------------------------
module class_argmax_writer #(
    parameter int IMAGE_WIDTH  = 32,
    parameter int IMAGE_HEIGHT = 32,
    parameter int NUM_CLASSES  = 21,
    parameter int SCORE_WIDTH  = 16,
    parameter int CONF_THRESH  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   score_valid,
    input  logic [SCORE_WIDTH-1:0] score_data,
    output logic                   score_ready,
    output logic                   wr_en,
    output logic [19:0]            wr_addr,
    output logic [7:0]             wr_data,
    output logic                   busy,
    output logic                   done
);

    localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam logic [CW-1:0] LAST_CLASS = CW'(NUM_CLASSES - 1);
    localparam logic [19:0]   LAST_PIXEL = 20'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);

`ifdef ARGMAX_CONF_THRESH_EN
    localparam logic signed [SCORE_WIDTH-1:0] THRESH = SCORE_WIDTH'(CONF_THRESH);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]                 cls_cnt;
    logic [19:0]                   pix_cnt;
    logic signed [SCORE_WIDTH-1:0] max_val;
    logic [CW-1:0]                 max_idx;

    logic signed [SCORE_WIDTH-1:0] score_s;
    logic signed [SCORE_WIDTH-1:0] cand_val;
    logic [CW-1:0]                 cand_idx;
    logic [7:0]                    result;
    logic                          beat;
    logic                          last_beat;
    logic                          frame_end;
    logic                          start_ok;

    // ------------------------------------------------------------------
    // Beat qualification and running-max candidate. The candidate already
    // includes the current beat so the final class beat can be written on
    // the very next edge without an extra pipeline stage.
    // ------------------------------------------------------------------
    always_comb begin
        score_s   = score_data;
        beat      = (state == S_RUN) && score_valid;
        last_beat = beat && (cls_cnt == LAST_CLASS);
        frame_end = last_beat && (pix_cnt == LAST_PIXEL);
        start_ok  = start && ((state == S_IDLE) || (state == S_DONE));

        cand_val = max_val;
        cand_idx = max_idx;
        if (cls_cnt == '0) begin
            cand_val = score_s;
            cand_idx = '0;
        end else if (score_s > max_val) begin
            // strict compare: ties keep the lower class index
            cand_val = score_s;
            cand_idx = cls_cnt;
        end

        result = 8'(cand_idx);
`ifdef ARGMAX_CONF_THRESH_EN
        if (cand_val < THRESH) begin
            result = '0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        score_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                score_ready = 1'b1;
                busy        = 1'b1;
                if (frame_end) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // final write strobe is on wr_en during this state
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = S_RUN;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, running max and write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cls_cnt <= '0;
            pix_cnt <= '0;
            max_val <= '0;
            max_idx <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            if (start_ok) begin
                cls_cnt <= '0;
                pix_cnt <= '0;
                max_val <= '0;
                max_idx <= '0;
            end else if (beat) begin
                max_val <= cand_val;
                max_idx <= cand_idx;
                if (last_beat) begin
                    wr_en   <= 1'b1;
                    wr_addr <= pix_cnt;
                    wr_data <= result;
                    cls_cnt <= '0;
                    pix_cnt <= pix_cnt + 20'd1;
                end else begin
                    cls_cnt <= cls_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_class_argmax_writer.sv
// -----------------------------------------------------------------------------
// tb_class_argmax_writer
//
// Directed self-checking bench for class_argmax_writer on a 2x2 image with
// four classes. Expected writes are pushed to a queue as each pixel is driven
// and popped by a monitor whenever the DUT strobes wr_en. Honours
// ARGMAX_CONF_THRESH_EN in its reference model.
// -----------------------------------------------------------------------------
module tb_class_argmax_writer;

    localparam int W  = 2;
    localparam int H  = 2;
    localparam int NC = 4;
    localparam int SW = 16;
    localparam int CT = 10;
    localparam int NP = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          score_valid = 1'b0;
    logic [SW-1:0] score_data = '0;
    logic          score_ready;
    logic          wr_en;
    logic [19:0]   wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    logic          done;

    class_argmax_writer #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .NUM_CLASSES (NC),
        .SCORE_WIDTH (SW),
        .CONF_THRESH (CT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .score_valid(score_valid),
        .score_data (score_data),
        .score_ready(score_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_pix  = 0;

    typedef struct packed {
        logic [19:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    int f1[NP][NC] = '{'{1, 5, 3, 2}, '{9, 0, 0, 0}, '{-4, -2, -8, -3}, '{0, 0, 0, 7}};
    int f2[NP][NC] = '{'{6, 6, 2, 6}, '{1, 8, 8, 0},
                       '{-32768, -32768, -32768, 32767},
                       '{-32768, -32768, -32768, -32768}};
    int f3[NP][NC] = '{'{0, 3, 1, 9}, '{2, 0, 10, 4}, '{-1, -1, -1, -1}, '{10, 10, 9, 0}};
    int p_big[NC]  = '{0, 0, 0, 70};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input int s[NC]);
        int best;
        best = 0;
        for (int k = 1; k < NC; k++) begin
            if (s[k] > s[best]) best = k;
        end
`ifdef ARGMAX_CONF_THRESH_EN
        if (s[best] < CT) return 8'd0;
`endif
        return 8'(best);
    endfunction

    // Entered and left at a falling edge; drives one beat per cycle, with
    // score_valid dropped for roughly gap_pct percent of cycles.
    task automatic send_pixel(input int s[NC], input int gap_pct);
        wr_t e;
        e.addr = 20'(exp_pix);
        e.data = model(s);
        exp_q.push_back(e);
        exp_pix++;
        for (int c = 0; c < NC; c++) begin
            logic ok;
            ok = 1'b0;
            while (!ok) begin
                score_valid = (int'($urandom_range(99)) >= gap_pct);
                score_data  = SW'(s[c]);
                ok = score_valid && score_ready;
                @(posedge clk);
                @(negedge clk);
            end
        end
        check("write_latency", wr_en, 1'b1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_ready", score_ready, 1'b1);
        check("start_done", done, 1'b0);
    endtask

    task automatic send_frame(input int f[NP][NC], input int gap_pct, input bit mid_start);
        exp_pix = 0;
        pulse_start();
        for (int p = 0; p < NP; p++) begin
            if (mid_start && p == 1) start = 1'b1;
            if (mid_start && p == 3) start = 1'b0;
            send_pixel(f[p], gap_pct);
        end
        start       = 1'b0;
        score_valid = 1'b0;
        check("flush_busy", busy, 1'b1);
        check("flush_ready", score_ready, 1'b0);
        check("flush_done", done, 1'b0);
        @(negedge clk);
        check("done_busy", busy, 1'b0);
        check("done_done", done, 1'b1);
        check("done_wr_en", wr_en, 1'b0);
        check("done_ready", score_ready, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_score_ready"}, score_ready, 1'b0);
        check({tag, "_wr_en"}, wr_en, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_wr_addr"}, wr_addr, 20'd0);
        check({tag, "_wr_data"}, wr_data, 8'd0);
    endtask

    // Write monitor / scoreboard
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("no_write_expected", wr_en, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", wr_addr, mon_e.addr);
                check("wr_data", wr_data, mon_e.data);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_ready", score_ready, 1'b0);

        // main frame, continuous valid
        send_frame(f1, 0, 1'b0);

        // beats in DONE are ignored (monitor flags any write)
        score_valid = 1'b1;
        repeat (3) @(negedge clk);
        score_valid = 1'b0;
        check("done_hold", done, 1'b1);
        check("done_hold_ready", score_ready, 1'b0);

        // restart from DONE: ties and extreme values
        send_frame(f2, 0, 1'b0);
        // threshold region
        send_frame(f3, 0, 1'b0);

        // random valid gaps with start pulsed mid-RUN
        send_frame(f1, 50, 1'b1);

        // reset mid-frame
        exp_pix = 0;
        pulse_start();
        send_pixel(f1[0], 0);
        send_pixel(p_big, 0);
        check("pre_reset_addr", wr_addr, 20'd1);
        #1 rst = 1'b0;
        #1 check_all_zero("async_reset");
        score_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_done", done, 1'b0);
        check("post_reset_busy", busy, 1'b0);
        check("post_reset_queue", exp_q.size(), 0);

        // fresh frame after reset starts at address 0
        send_frame(f1, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
